// File: rtl/accum_bank_pkg.sv
// ---------------------------------------------------------------------------
// accum_bank_pkg
//
// Shared definitions for the accumulator bank:
//   MODE_WRAP / MODE_SAT : values of the SATURATE parameter
//                          (wrap-around or clamp at all-ones on carry)
//   calc_cw()            : index width for a count of items, never less
//                          than one bit, so a single-item bank still has
//                          a legal one-bit select port.
// ---------------------------------------------------------------------------
package accum_bank_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Width of an index able to address n items (minimum 1 bit).
  function automatic int calc_cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/accum_lane.sv
// ---------------------------------------------------------------------------
// accum_lane
//
// One channel of the accumulator bank: running sum, sample counter and
// sticky overflow flag. The lane reports a frame completion combinationally
// in the cycle of the completing accept, together with the final sum and
// overflow flag, and returns itself to zero on that same edge.
//
// Ports
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset, clears all lane state
//   i_clear   : synchronous flush, clears all lane state, drops the sample
//   i_accept  : a sample addressed to this lane is accepted this cycle
//   i_data    : sample value
//   o_done    : this accept completes the frame (counter at LENGTH-1)
//   o_sum     : acc + i_data, wrapped or clamped according to SATURATE
//   o_ovf     : sticky overflow of the frame including this sample's carry
// ---------------------------------------------------------------------------
module accum_lane
  import accum_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LENGTH   = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  localparam int             NW   = calc_cw(LENGTH);
  localparam logic [NW-1:0]  LAST = NW'(LENGTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [NW-1:0]    r_count;
  logic             r_ovf;

  logic [WIDTH:0]   w_sum_ext;
  logic             w_carry;
  logic             w_take;

  // One extra bit on the adder exposes the carry that marks an overflow.
  assign w_sum_ext = {1'b0, r_acc} + {1'b0, i_data};
  assign w_carry   = w_sum_ext[WIDTH];

  // A flush in the same cycle wins over the sample.
  assign w_take    = i_accept & ~i_clear;

  assign o_sum  = ((SATURATE == MODE_SAT) && w_carry) ? {WIDTH{1'b1}}
                                                     : w_sum_ext[WIDTH-1:0];
  assign o_done = w_take & (r_count == LAST);
  assign o_ovf  = r_ovf | w_carry;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (o_done) begin
      // The finished sum leaves through the top's output register.
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_take) begin
      r_acc   <= o_sum;
      r_count <= r_count + NW'(1);
      r_ovf   <= o_ovf;
    end
  end

endmodule

// File: rtl/accum_bank.sv
// ---------------------------------------------------------------------------
// accum_bank
//
// Bank of CHANNELS independent frame accumulators. Each accepted sample is
// added to the accumulator selected by in_chan; after LENGTH samples to a
// channel the frame sum is placed in a one-deep output register with a
// valid/ready handshake. Samples aimed at a channel that does not exist are
// accepted and dropped.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset (highest priority)
//   clear      : synchronous flush of all lanes; output register untouched
//   in_valid   : sample present
//   in_ready   : sample can be accepted (= !out_valid | out_ready)
//   in_data    : sample value
//   in_chan    : target channel
//   out_valid  : frame result present
//   out_ready  : consumer takes the result this cycle
//   out_data   : frame sum
//   out_chan   : channel of the frame sum
//   out_ovf    : an overflow occurred during the frame
// ---------------------------------------------------------------------------
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int LENGTH   = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [calc_cw(CHANNELS)-1:0]  in_chan,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [calc_cw(CHANNELS)-1:0]  out_chan,
  output logic                          out_ovf
);

  localparam int          CW       = calc_cw(CHANNELS);
  localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CHANNELS);

  // Output register occupancy.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_chan;
  logic             r_out_ovf;

  logic             w_accept;
  logic             w_chan_ok;
  logic [CHANNELS-1:0] w_lane_accept;
  logic [CHANNELS-1:0] w_lane_done;
  logic [CHANNELS-1:0] w_lane_ovf;
  logic [WIDTH-1:0]    w_lane_sum [CHANNELS];

  logic             w_done;
  logic [WIDTH-1:0] w_done_sum;
  logic             w_done_ovf;

  // -------------------------------------------------------------------------
  // Input handshake
  // -------------------------------------------------------------------------
  // in_ready depends only on the output register, never on in_valid, so an
  // upstream source may legally wait for ready before raising valid.
  assign in_ready  = (r_state == ST_EMPTY) | out_ready;
  assign w_accept  = in_valid & in_ready;

  // Widen by one bit so the compare also works when CHANNELS is not a
  // power of two and in_chan can name a missing channel.
  assign w_chan_ok = ({1'b0, in_chan} < CH_LIMIT);

  // -------------------------------------------------------------------------
  // Lanes
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign w_lane_accept[g] = w_accept & w_chan_ok & (in_chan == CW'(g));

    accum_lane #(
      .WIDTH    (WIDTH),
      .LENGTH   (LENGTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (clear),
      .i_accept (w_lane_accept[g]),
      .i_data   (in_data),
      .o_done   (w_lane_done[g]),
      .o_sum    (w_lane_sum[g]),
      .o_ovf    (w_lane_ovf[g])
    );
  end

  // At most one lane is addressed per cycle, so at most one can complete.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value (which would infer a latch).
  always_comb begin
    w_done     = 1'b0;
    w_done_sum = '0;
    w_done_ovf = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_lane_done[i]) begin
        w_done     = 1'b1;
        w_done_sum = w_lane_sum[i];
        w_done_ovf = w_lane_ovf[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  // A completion needs an accept, which needs in_ready, so a new result can
  // only arrive while the register is empty or being drained this cycle;
  // the held result therefore never changes while out_valid & !out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_out_data <= '0;
      r_out_chan <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_done) begin
      r_state    <= ST_FULL;
      r_out_data <= w_done_sum;
      r_out_chan <= in_chan;
      r_out_ovf  <= w_done_ovf;
    end else if (out_ready) begin
      r_state    <= ST_EMPTY;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_accum_bank.sv
// ---------------------------------------------------------------------------
// tb_accum_bank
//
// Three instances share one stimulus stream:
//   d0 : defaults (wrap, 4 channels, LENGTH 8)
//   d1 : SATURATE=1 with 3 channels (channel 3 does not exist)
//   d2 : LENGTH=1 (every accept completes a frame)
// A reference model per instance pushes expected frame results into a
// scoreboard queue; results are popped as each instance presents them.
// ---------------------------------------------------------------------------
module tb_accum_bank;

  localparam int ND = 3;
  localparam int LEN [ND] = '{8, 8, 1};
  localparam int CHN [ND] = '{4, 3, 4};
  localparam int SAT [ND] = '{0, 1, 0};

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  chan;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_chan;
  logic        out_ready;

  logic        in_ready  [ND];
  logic        out_valid [ND];
  logic [15:0] out_data  [ND];
  logic [1:0]  out_chan  [ND];
  logic        out_ovf   [ND];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] m_acc [ND][4];
  int          m_cnt [ND][4];
  logic        m_ovf [ND][4];
  logic        m_valid [ND];
  logic        seen [ND];
  exp_t        cur [ND];
  exp_t        sb [ND][$];

  accum_bank u_d0 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .out_chan(out_chan[0]), .out_ovf(out_ovf[0])
  );

  accum_bank #(.SATURATE(1), .CHANNELS(3)) u_d1 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .out_chan(out_chan[1]), .out_ovf(out_ovf[1])
  );

  accum_bank #(.LENGTH(1)) u_d2 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
    .out_chan(out_chan[2]), .out_ovf(out_ovf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model update on each rising edge (inputs are stable here)
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    logic        acc_ok;
    logic        done;
    logic [16:0] s;
    logic [15:0] res;
    int          c;
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        for (int k = 0; k < 4; k++) begin
          m_acc[d][k] = '0; m_cnt[d][k] = 0; m_ovf[d][k] = 1'b0;
        end
        m_valid[d] = 1'b0;
        seen[d]    = 1'b0;
        sb[d].delete();
      end else begin
        acc_ok = in_valid && (!m_valid[d] || out_ready);
        done   = 1'b0;
        if (clear) begin
          for (int k = 0; k < 4; k++) begin
            m_acc[d][k] = '0; m_cnt[d][k] = 0; m_ovf[d][k] = 1'b0;
          end
        end else if (acc_ok && (int'(in_chan) < CHN[d])) begin
          c   = int'(in_chan);
          s   = {1'b0, m_acc[d][c]} + {1'b0, in_data};
          res = (SAT[d] == 1 && s[16]) ? 16'hFFFF : s[15:0];
          if (m_cnt[d][c] == LEN[d] - 1) begin
            sb[d].push_back('{data: res, chan: in_chan, ovf: m_ovf[d][c] | s[16]});
            m_acc[d][c] = '0; m_cnt[d][c] = 0; m_ovf[d][c] = 1'b0;
            done = 1'b1;
          end else begin
            m_acc[d][c] = res;
            m_cnt[d][c] = m_cnt[d][c] + 1;
            m_ovf[d][c] = m_ovf[d][c] | s[16];
          end
        end
        if (done) begin
          m_valid[d] = 1'b1;
          seen[d]    = 1'b0;
        end else if (out_ready) begin
          m_valid[d] = 1'b0;
          seen[d]    = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output comparison on each falling edge
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("d%0d out_valid", d), 32'(out_valid[d]), 32'(m_valid[d]));
        check($sformatf("d%0d in_ready", d), 32'(in_ready[d]), 32'(!m_valid[d] || out_ready));
        if (out_valid[d] && !seen[d]) begin
          if (sb[d].size() == 0) begin
            check($sformatf("d%0d unexpected result", d), 32'd1, 32'd0);
          end else begin
            cur[d]  = sb[d].pop_front();
            seen[d] = 1'b1;
          end
        end
        if (out_valid[d] && seen[d]) begin
          check($sformatf("d%0d out_data", d), 32'(out_data[d]), 32'(cur[d].data));
          check($sformatf("d%0d out_chan", d), 32'(out_chan[d]), 32'(cur[d].chan));
          check($sformatf("d%0d out_ovf", d),  32'(out_ovf[d]),  32'(cur[d].ovf));
        end
      end
    end
  end

  // Drive one sample; returns 1 time unit after the edge that sampled it.
  task automatic send(input logic [1:0] c, input logic [15:0] v);
    in_valid = 1'b1;
    in_chan  = c;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chan   = '0;
    out_ready = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d rst in_ready", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("d%0d rst out_valid", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("d%0d rst out_data", d), 32'(out_data[d]), 32'd0);
      check($sformatf("d%0d rst out_chan", d), 32'(out_chan[d]), 32'd0);
      check($sformatf("d%0d rst out_ovf", d), 32'(out_ovf[d]), 32'd0);
    end
    @(posedge clk); #1;

    // Channel 0 receives 1..8
    for (int i = 1; i <= 8; i++) send(2'd0, 16'(i));
    @(negedge clk);
    check("sum 1..8 valid", 32'(out_valid[0]), 32'd1);
    check("sum 1..8 data", 32'(out_data[0]), 32'd36);
    check("sum 1..8 ovf", 32'(out_ovf[0]), 32'd0);
    @(posedge clk); #1;
    idle(1);

    // Overflow: wrap and saturate
    send(2'd1, 16'hFFFF);
    send(2'd1, 16'h0002);
    for (int i = 0; i < 6; i++) send(2'd1, 16'h0000);
    @(negedge clk);
    check("wrap data", 32'(out_data[0]), 32'h0001);
    check("wrap ovf", 32'(out_ovf[0]), 32'd1);
    check("sat data", 32'(out_data[1]), 32'hFFFF);
    check("sat ovf", 32'(out_ovf[1]), 32'd1);
    @(posedge clk); #1;
    idle(2);

    // Backpressure: complete a frame with out_ready low, hold for 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(2'd0, 16'd1);
    in_valid = 1'b1;
    in_chan  = 2'd0;
    in_data  = 16'd100;
    idle(5);
    check("stall in_ready", 32'(in_ready[0]), 32'd0);
    check("stall out_data", 32'(out_data[0]), 32'd8);
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release out_valid", 32'(out_valid[0]), 32'd0);
    for (int i = 0; i < 7; i++) send(2'd0, 16'd1);
    @(negedge clk);
    check("post-stall data", 32'(out_data[0]), 32'd107);
    @(posedge clk); #1;
    idle(2);

    // Interleaved channels 2 and 3
    for (int i = 0; i < 8; i++) begin
      send(2'd2, 16'd1);
      send(2'd3, 16'd2);
    end
    @(negedge clk);
    check("interleave last data", 32'(out_data[0]), 32'd16);
    check("interleave last chan", 32'(out_chan[0]), 32'd3);
    @(posedge clk); #1;
    idle(2);

    // Clear at count 5 drops the sample; next full frame sums to 8
    for (int i = 0; i < 5; i++) send(2'd0, 16'd1);
    clear = 1'b1;
    send(2'd0, 16'd50);
    clear = 1'b0;
    for (int i = 0; i < 8; i++) send(2'd0, 16'd1);
    @(negedge clk);
    check("after clear data", 32'(out_data[0]), 32'd8);
    @(posedge clk); #1;
    idle(2);

    // Reset mid-frame at count 3
    for (int i = 0; i < 3; i++) send(2'd0, 16'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d mid rst out_valid", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("d%0d mid rst out_data", d), 32'(out_data[d]), 32'd0);
      check($sformatf("d%0d mid rst out_ovf", d), 32'(out_ovf[d]), 32'd0);
    end
    @(posedge clk); #1;

    // The discarded partial frame must not leak into the next one
    for (int i = 0; i < 8; i++) send(2'd0, 16'd2);
    @(negedge clk);
    check("post rst frame", 32'(out_data[0]), 32'd16);
    @(posedge clk); #1;
    idle(3);

    for (int d = 0; d < ND; d++)
      check($sformatf("d%0d scoreboard drained", d), 32'(sb[d].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter WIDTH, default 16, data and accumulator width in bits (unsigned).
REQ-002 Parameter CHANNELS, default 4, number of independent accumulators.
REQ-003 Parameter LENGTH, default 8, accepted samples per channel frame (>=1).
REQ-004 Parameter SATURATE, default 0, 0 = wrap-around, 1 = clamp at all-ones.
REQ-005 clk  input  1  the block's only clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clear  input  1  synchronous flush of all channel accumulators.
REQ-008 in_valid  input  1  sample present.
REQ-009 in_ready  output  1  sample can be accepted this cycle.
REQ-010 in_data  input  WIDTH  sample value.
REQ-011 in_chan  input  CW = max(1,clog2(CHANNELS))  target channel.
REQ-012 out_valid  output  1  frame result present.
REQ-013 out_ready  input  1  consumer takes result this cycle.
REQ-014 out_data  output  WIDTH  frame sum.
REQ-015 out_chan  output  CW  channel of frame sum.
REQ-016 out_ovf  output  1  overflow occurred during this frame.

Function
REQ-017 Accept = in_valid & in_ready; in_ready SHALL equal !out_valid | out_ready (combinational, no dependency on in_valid).
REQ-018 On accept, sum = acc[in_chan] + in_data computed at WIDTH+1 bits; carry bit = overflow.
REQ-019 SATURATE=0: acc stores sum[WIDTH-1:0]; SATURATE=1: on carry acc stores all-ones, else sum.
REQ-020 Per-channel sticky ovf flag SHALL set on any carry within the frame.
REQ-021 Per-channel sample counter (0..LENGTH-1) SHALL increment on each accept to that channel.
REQ-022 Accept with counter = LENGTH-1 completes the frame: next edge loads out_data = final (wrapped/clamped) sum, out_chan, out_ovf = sticky | this carry, sets out_valid; that channel's acc, counter, ovf SHALL clear to 0 on the same edge.
REQ-023 Latency: out_valid high exactly one cycle after the completing accept edge.
REQ-024 Output register states: EMPTY (out_valid=0) -> FULL on frame completion; FULL -> EMPTY on out_ready with no completion; FULL -> FULL (new result loaded) when out_ready and a completion coincide.
REQ-025 out_data/out_chan/out_ovf SHALL remain stable while out_valid & !out_ready.
REQ-026 in_chan >= CHANNELS: sample accepted and discarded; no accumulator, counter, flag change.
REQ-027 clear has priority over a same-cycle accept: all acc, counters, flags -> 0, sample dropped; output register and out_valid unaffected.
REQ-028 LENGTH=1: every accept completes a frame; out_data = in_data (no carry possible).
REQ-029 Channels SHALL be independent; interleaved samples to different channels never interact.

Reset
REQ-030 reset SHALL set all acc, counters, sticky flags, out_data, out_chan, out_ovf to 0 and out_valid to 0 on the next rising edge.
REQ-031 reset SHALL take priority over clear, accept, and out_ready; a partially accumulated frame is discarded.
REQ-032 in_ready SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-033 Shared package SHALL hold the mode constants (MODE_WRAP=0, MODE_SAT=1) and the CW width function.
REQ-034 One sub-module accum_lane (single-channel acc + counter + sticky flag, WIDTH/LENGTH/SATURATE parameters) SHALL be instantiated CHANNELS times; output register and handshake live in the top.

Verification
REQ-035 Defaults, channel 0 receives 1..8 with out_ready=1 -> one cycle after 8th accept: out_valid=1, out_data=36, out_chan=0, out_ovf=0.
REQ-036 SATURATE=0, channel 1 receives 0xFFFF, 0x0002, then six zeros -> out_data=0x0001, out_ovf=1; SATURATE=1 same stimulus -> out_data=0xFFFF, out_ovf=1.
REQ-037 Complete frame with out_ready=0 for 5 cycles -> in_ready=0, out_data held; out_ready=1 -> in_ready=1 same cycle, out_valid falls next edge.
REQ-038 Interleave channels 2 and 3 (2: all 1s, 3: all 2s) -> results 8 on chan 2 then 16 on chan 3, in completion order.
REQ-039 Channel 0 at count 5, assert clear with in_valid -> sample dropped; next 8 samples of 1 produce out_data=8; reset at count 3 produces no output and all outputs 0.
